// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the digit type, FSM state encoding and the digit-count sizing helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;

    // Smallest digit count whose decimal range covers the largest WIDTH-bit value.
    function automatic int min_digits(input int width);
        longint unsigned maxValue;
        longint unsigned power;
        int              digits;
        maxValue = (64'd1 << width) - 64'd1;
        power    = 64'd1;
        digits   = 0;
        for (int i = 0; i < 20; i++) begin
            if (power <= maxValue) begin
                power  = power * 64'd10;
                digits = digits + 1;
            end
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD field holding 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESHOLD) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Optional macro SIGNED_INPUT_EN: two's-complement input with a sign_out port.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      d_input,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef SIGNED_INPUT_EN
    ,
    output logic                  sign_out
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 4 || DIGITS < min_digits(WIDTH)) begin : gBadParams
        $error("bin_to_bcd_seq: WIDTH must be >= 4 and DIGITS large enough for WIDTH");
    end

    state_e          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;

    logic [BW-1:0]   adjDigits;
    logic [SW-1:0]   shifted;
    logic [WIDTH-1:0] loadValue;
    logic            lastStep;

`ifdef SIGNED_INPUT_EN
    logic            signPend_q, signPend_d;
    logic            sign_q, sign_d;

    assign loadValue = d_input[WIDTH-1] ? -d_input : d_input;
`else
    assign loadValue = d_input;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : gDigit
        bcd_digit_adj uAdj (
            .digit_i (shift_q[WIDTH + 4*g +: 4]),
            .digit_o (adjDigits[4*g +: 4])
        );
    end

    assign shifted  = {adjDigits, shift_q[WIDTH-1:0]} << 1;
    assign lastStep = (state_q == CONV) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = CONV;
            CONV:    if (lastStep) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == CONV);
        done    = done_q;
        bcd_out = bcd_q;
`ifdef SIGNED_INPUT_EN
        sign_out = sign_q;
`endif
    end

    // The result register only changes on the final step, so intermediate
    // shift states never reach the display side.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
`ifdef SIGNED_INPUT_EN
        signPend_d = signPend_q;
        sign_d     = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {{BW{1'b0}}, loadValue};
                    cnt_d   = CW'(WIDTH);
`ifdef SIGNED_INPUT_EN
                    signPend_d = d_input[WIDTH-1];
`endif
                end
            end
            CONV: begin
                shift_d = shifted;
                cnt_d   = cnt_q - CW'(1);
                if (lastStep) begin
                    bcd_d  = shifted[SW-1 -: BW];
                    done_d = 1'b1;
`ifdef SIGNED_INPUT_EN
                    sign_d = signPend_q;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
`ifdef SIGNED_INPUT_EN
            signPend_q <= 1'b0;
            sign_q     <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
`ifdef SIGNED_INPUT_EN
            signPend_q <= signPend_d;
            sign_q     <= sign_d;
`endif
        end
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter controller using iterative double-dabble (shift-and-add-3), one bit per clock.
- Sits between the recorder's sample/counter datapath (16-bit values) and the display driver, which needs decimal digits.
- Owns the conversion sequencing: start/busy/done handshake, iteration counter, and the shift register holding the BCD digits and remaining binary bits.

Parameters:
- WIDTH, 16, binary input width in bits; must be ≥ 4.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1 (5 covers 65535).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a conversion; sampled only when busy=0.
- d_input  input  WIDTH  binary value; captured on the cycle start is accepted.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bcd_out valid and updated this cycle.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) is bcd_out[3:0].
- sign_out  output  1  sign of the last converted value (present only with SIGNED_INPUT_EN).

Behaviour:
- Reset: rst_n=0 at a posedge sets state=IDLE, busy=0, done=0, bcd_out=0, sign_out=0, iteration counter=0, and clears the shift register.
- Reset mid-conversion aborts the conversion with no done pulse and zeroes bcd_out.
- FSM states: IDLE and CONV.
- IDLE, start=1 (edge k): load shift reg = {4*DIGITS zeros, d_input}, counter=WIDTH, go to CONV. busy=1 from edge k.
- CONV, each cycle:
  - For every BCD digit field ≥5, add 3 (combinational adjust).
  - Then shift the whole register left by 1 and decrement the counter.
- CONV, counter reaching 0 (edge k+WIDTH):
  - bcd_out ← upper 4*DIGITS bits of the shifted result.
  - done=1 for exactly that one cycle; busy=0; state=IDLE.
- Latency: done is high during the cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance (16 for default).
- start while busy=1: ignored, no queueing. d_input changes during CONV have no effect.
- start=1 in the same cycle done=1: accepted (state is IDLE); the next conversion begins. Back-to-back throughput is one result per WIDTH+1 cycles.
- bcd_out holds its last value between conversions; it never shows intermediate shift states.
- Arithmetic: add-3 is applied per 4-bit field with no carry between fields. Given the DIGITS constraint, the top digit never overflows.
- done is never asserted while busy=1 is being newly set by the same edge, except for the accepted back-to-back start case above.

Optional Feature:
- Macro: SIGNED_INPUT_EN.
- Defined:
  - d_input is treated as two's complement.
  - On acceptance, magnitude = d_input[WIDTH-1] ? −d_input : d_input, taken as WIDTH-bit unsigned. The value 0x8000 therefore yields 32768, which still fits.
  - sign_out ← d_input[WIDTH-1], updated on the same edge as bcd_out; it holds otherwise.
- Undefined: input is unsigned; sign_out port and its logic are absent.

Decomposition:
- Shared package bcd_pkg:
  - BCD digit typedef (4-bit).
  - State enum {IDLE, CONV}.
  - Constant ADD3_THRESHOLD=5.
  - Helper function computing the minimum DIGITS for a given WIDTH, used in an elaboration-time check.
- Sub-module bcd_digit_adj: 4-bit in → 4-bit out, adds 3 when in ≥ 5. Instantiated DIGITS times via generate.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset, then d_input=16'hFFFF with start pulse → busy for 16 cycles; done single pulse; bcd_out=20'h65535.
- d_input=16'h0000 → bcd_out=20'h00000. Then d_input=16'h2710 → bcd_out=20'h10000, with done exactly 16 cycles after acceptance.
- start accepted with 16'h00FF; start held high and d_input changed to 16'h1234 during CONV → only one done; bcd_out=20'h00255. With start still high at done, the next result is 20'h04660.
- Start 16'h3039 and assert rst_n=0 at cycle 8 → no done pulse; bcd_out=0, busy=0 next cycle; a fresh start then converts normally to 20'h12345.
- SIGNED_INPUT_EN build:
  - 16'h8000 → sign_out=1, bcd_out=20'h32768.
  - 16'hFFFF → sign_out=1, bcd_out=20'h00001.
  - 16'h7FFF → sign_out=0, bcd_out=20'h32767.
